dds_sweep_ctrl: RTL and testbench

//  Frequency-sweep sequencer for the DDS sine channel. Drives the tuning word (Step)
//  and phase offset (phase) of the sine generator with a linear sweep from a start to a

---
 rtl/dds_sweep_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl
//   Frequency-sweep sequencer for the DDS sine channel. Produces a linear
//   sweep of the tuning word (Step) between a start and a stop value, holding
//   each value for a programmable dwell, plus a constant phase offset.
//   Supports single-shot, repeat and up-down sweeps with a start/abort
//   handshake. All outputs are registered; the sine generator samples them on
//   the falling edge.
//
// Ports
//   clk         system clock, all state changes on posedge
//   reset       asynchronous active-low reset
//   cfg_start   first tuning word of the sweep
//   cfg_stop    final tuning word of the sweep
//   cfg_delta   unsigned tuning-word increment per step
//   cfg_dwell   extra hold cycles per step (value held cfg_dwell+1 cycles)
//   cfg_mode    0 single, 1 repeat, 2 up-down, 3 treated as single
//   cfg_phase   phase offset applied for the whole sweep
//   start       one-cycle request, accepted only while idle
//   abort       stops the sweep from any state
//   Step        tuning word to the sine generator
//   phase       phase offset to the sine generator
//   busy        high while sweeping
//   done        one-cycle pulse on normal completion (single mode only)
//   sweep_down  current direction, 1 = decrementing (up-down mode only)
//
// States
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start; outputs hold their last values
//   ST_RUN   | sweeping; dwell counter runs, step action when it hits zero
// ---------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int W       = 32,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [W-1:0]       cfg_start,
    input  logic [W-1:0]       cfg_stop,
    input  logic [W-1:0]       cfg_delta,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic [W-1:0]       cfg_phase,
    input  logic               start,
    input  logic               abort,
    output logic [W-1:0]       Step,
    output logic [W-1:0]       phase,
    output logic               busy,
    output logic               done,
    output logic               sweep_down
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Configuration captured at start so cfg_* may change freely mid-sweep.
    logic [W-1:0]       sh_start, sh_start_nxt;
    logic [W-1:0]       sh_stop, sh_stop_nxt;
    logic [W-1:0]       sh_delta, sh_delta_nxt;
    logic [DWELL_W-1:0] sh_dwell, sh_dwell_nxt;
    logic [1:0]         sh_mode, sh_mode_nxt;

    logic [DWELL_W-1:0] count, count_nxt;
    logic [W-1:0]       step_nxt;
    logic [W-1:0]       phase_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               sweep_down_nxt;

    // One extra bit catches carry/borrow so a wrapped result clamps to the
    // endpoint instead of jumping to the opposite end of the range.
    logic [W:0]   sum_ext;
    logic [W:0]   diff_ext;
    logic [W-1:0] step_up;
    logic [W-1:0] step_dn;
    logic         up_end;
    logic         dn_end;
    logic         mode_repeat;
    logic         mode_updown;

    always_comb begin
        sum_ext  = {1'b0, Step} + {1'b0, sh_delta};
        diff_ext = {1'b0, Step} - {1'b0, sh_delta};

        if (sum_ext[W] || (sum_ext[W-1:0] > sh_stop))
            step_up = sh_stop;
        else
            step_up = sum_ext[W-1:0];

        if (diff_ext[W] || (diff_ext[W-1:0] < sh_start))
            step_dn = sh_start;
        else
            step_dn = diff_ext[W-1:0];

        up_end      = (Step >= sh_stop)  || (sh_delta == '0);
        dn_end      = (Step <= sh_start) || (sh_delta == '0);
        mode_repeat = (sh_mode == 2'd1);
        mode_updown = (sh_mode == 2'd2);
    end

    always_comb begin
        state_nxt      = state;
        sh_start_nxt   = sh_start;
        sh_stop_nxt    = sh_stop;
        sh_delta_nxt   = sh_delta;
        sh_dwell_nxt   = sh_dwell;
        sh_mode_nxt    = sh_mode;
        count_nxt      = count;
        step_nxt       = Step;
        phase_nxt      = phase;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        sweep_down_nxt = sweep_down;

        if (abort) begin
            // Step and phase freeze where they are; no done pulse even if an
            // end action would have happened on this edge.
            state_nxt      = ST_IDLE;
            busy_nxt       = 1'b0;
            sweep_down_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    busy_nxt = 1'b0;
                    if (start) begin
                        sh_start_nxt   = cfg_start;
                        sh_stop_nxt    = cfg_stop;
                        sh_delta_nxt   = cfg_delta;
                        sh_dwell_nxt   = cfg_dwell;
                        sh_mode_nxt    = cfg_mode;
                        step_nxt       = cfg_start;
                        phase_nxt      = cfg_phase;
                        count_nxt      = cfg_dwell;
                        busy_nxt       = 1'b1;
                        sweep_down_nxt = 1'b0;
                        state_nxt      = ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (count != '0) begin
                        count_nxt = count - DWELL_W'(1);
                    end else begin
                        count_nxt = sh_dwell;
                        if (sweep_down) begin
                            if (dn_end) begin
                                // Bottom reached: turn around and take the
                                // first upward step on the same edge.
                                sweep_down_nxt = 1'b0;
                                step_nxt       = step_up;
                            end else begin
                                step_nxt = step_dn;
                            end
                        end else if (up_end) begin
                            if (mode_updown) begin
                                sweep_down_nxt = 1'b1;
                                step_nxt       = step_dn;
                            end else if (mode_repeat) begin
                                step_nxt = sh_start;
                            end else begin
                                state_nxt = ST_IDLE;
                                busy_nxt  = 1'b0;
                                done_nxt  = 1'b1;
                            end
                        end else begin
                            step_nxt = step_up;
                        end
                    end
                end

                default: begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            sh_start   <= '0;
            sh_stop    <= '0;
            sh_delta   <= '0;
            sh_dwell   <= '0;
            sh_mode    <= '0;
            count      <= '0;
            Step       <= '0;
            phase      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sweep_down <= 1'b0;
        end else begin
            state      <= state_nxt;
            sh_start   <= sh_start_nxt;
            sh_stop    <= sh_stop_nxt;
            sh_delta   <= sh_delta_nxt;
            sh_dwell   <= sh_dwell_nxt;
            sh_mode    <= sh_mode_nxt;
            count      <= count_nxt;
            Step       <= step_nxt;
            phase      <= phase_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            sweep_down <= sweep_down_nxt;
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Testbench for dds_sweep_ctrl. Expected tuning-word sequences are generated
// from the sweep rules with 64-bit arithmetic and compared each cycle.
module tb_dds_sweep_ctrl;

    localparam int W       = 32;
    localparam int DWELL_W = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [W-1:0]       cfg_start;
    logic [W-1:0]       cfg_stop;
    logic [W-1:0]       cfg_delta;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [1:0]         cfg_mode;
    logic [W-1:0]       cfg_phase;
    logic               start;
    logic               abort;
    logic [W-1:0]       Step;
    logic [W-1:0]       phase;
    logic               busy;
    logic               done;
    logic               sweep_down;

    int total = 0;
    int bad   = 0;

    logic [31:0] obs_vals[$];
    int          obs_busy;
    int          obs_done;

    dds_sweep_ctrl #(.W(W), .DWELL_W(DWELL_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_start  (cfg_start),
        .cfg_stop   (cfg_stop),
        .cfg_delta  (cfg_delta),
        .cfg_dwell  (cfg_dwell),
        .cfg_mode   (cfg_mode),
        .cfg_phase  (cfg_phase),
        .start      (start),
        .abort      (abort),
        .Step       (Step),
        .phase      (phase),
        .busy       (busy),
        .done       (done),
        .sweep_down (sweep_down)
    );

    always #5 clk = ~clk;

    task automatic scramble_cfg();
        cfg_start = $urandom;
        cfg_stop  = $urandom;
        cfg_delta = $urandom;
        cfg_dwell = 16'($urandom);
        cfg_mode  = 2'($urandom);
        cfg_phase = $urandom;
    endtask

    // Called at a negedge with the DUT idle. Runs one sweep and checks every
    // cycle. Single mode returns at the negedge where done is visible; repeat
    // and up-down modes are aborted after run_cycles and return idle.
    task automatic run_and_check_sweep(input logic [31:0] s, input logic [31:0] e,
                                       input logic [31:0] d, input logic [15:0] dw,
                                       input logic [1:0] m, input logic [31:0] ph,
                                       input int run_cycles, input bit poke_start);
        logic [31:0] exp_step[$];
        bit          exp_sd[$];
        longint      v, vs, ve, vd;
        bit          down;
        bit          cont;
        int          n;
        logic [66:0] got, want;

        vs = longint'(s);
        ve = longint'(e);
        vd = longint'(d);
        v  = vs;
        down = 1'b0;
        cont = (m == 2'd1) || (m == 2'd2);

        if (cont) begin
            while (exp_step.size() < run_cycles) begin
                for (int k = 0; k <= int'(dw); k++) begin
                    exp_step.push_back(32'(v));
                    exp_sd.push_back(down);
                end
                if (!down) begin
                    if (v >= ve || vd == 0) begin
                        if (m == 2'd1) v = vs;
                        else begin
                            down = 1'b1;
                            v = (v - vd < vs) ? vs : v - vd;
                        end
                    end else begin
                        v = (v + vd > ve) ? ve : v + vd;
                    end
                end else begin
                    if (v <= vs || vd == 0) begin
                        down = 1'b0;
                        v = (v + vd > ve) ? ve : v + vd;
                    end else begin
                        v = (v - vd < vs) ? vs : v - vd;
                    end
                end
            end
            n = run_cycles;
        end else begin
            for (int g = 0; g < 20000; g++) begin
                for (int k = 0; k <= int'(dw); k++) begin
                    exp_step.push_back(32'(v));
                    exp_sd.push_back(1'b0);
                end
                if (v >= ve || vd == 0) break;
                v = (v + vd > ve) ? ve : v + vd;
            end
            n = exp_step.size();
        end

        obs_vals.delete();
        obs_busy = 0;
        obs_done = 0;

        cfg_start = s;
        cfg_stop  = e;
        cfg_delta = d;
        cfg_dwell = dw;
        cfg_mode  = m;
        cfg_phase = ph;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble_cfg();

        for (int i = 0; i < n; i++) begin
            got  = {Step, phase, busy, done, sweep_down};
            want = {exp_step[i], ph, 1'b1, 1'b0, exp_sd[i]};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL sweep_cycle mode=%0d i=%0d got=%h exp=%h", m, i, got, want);
            end
            if (obs_vals.size() == 0 || obs_vals[obs_vals.size()-1] != Step)
                obs_vals.push_back(Step);
            if (busy) obs_busy++;
            if (done) obs_done++;
            if (poke_start && $urandom_range(0, 7) == 0) begin
                scramble_cfg();
                start = 1'b1;
            end
            if (cont && i == n - 1) abort = 1'b1;
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
        end

        if (cont) begin
            got  = {Step, phase, busy, done, sweep_down};
            want = {exp_step[n-1], ph, 1'b0, 1'b0, 1'b0};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL sweep_abort mode=%0d got=%h exp=%h", m, got, want);
            end
        end else begin
            got  = {Step, phase, busy, done, sweep_down};
            want = {exp_step[n-1], ph, 1'b0, 1'b1, 1'b0};
            if (done) obs_done++;
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL sweep_done mode=%0d got=%h exp=%h", m, got, want);
            end
        end
    endtask

    task automatic test_reset();
        logic [66:0] got;
        got = {Step, phase, busy, done, sweep_down};
        total++;
        if (got !== 67'd0) begin
            bad++;
            $display("FAIL reset_state got=%h exp=0", got);
        end
    endtask

    task automatic test_single();
        run_and_check_sweep(32'd100, 32'd130, 32'd10, 16'd2, 2'd0, 32'h1234_5678, 0, 1'b0);
        total++;
        if (obs_busy != 12) begin
            bad++;
            $display("FAIL single_busy_len got=%0d exp=12", obs_busy);
        end
        total++;
        if (obs_vals.size() != 4 || obs_vals[0] != 100 || obs_vals[1] != 110 ||
            obs_vals[2] != 120 || obs_vals[3] != 130) begin
            bad++;
            $display("FAIL single_values got_count=%0d exp=100,110,120,130", obs_vals.size());
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || Step !== 32'd130) begin
            bad++;
            $display("FAIL single_done_once got done=%b busy=%b step=%h exp done=0 busy=0 step=82",
                     done, busy, Step);
        end
        total++;
        if (obs_done != 1) begin
            bad++;
            $display("FAIL single_done_count got=%0d exp=1", obs_done);
        end
    endtask

    task automatic test_clamp();
        logic [31:0] exp_list[4];
        exp_list = '{32'd0, 32'd10, 32'd20, 32'd25};
        run_and_check_sweep(32'd0, 32'd25, 32'd10, 16'd0, 2'd0, 32'd0, 0, 1'b0);
        total++;
        if (obs_vals.size() != 4) begin
            bad++;
            $display("FAIL clamp_count got=%0d exp=4", obs_vals.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (obs_vals[i] !== exp_list[i]) begin
                    bad++;
                    $display("FAIL clamp_value i=%0d got=%0d exp=%0d", i, obs_vals[i], exp_list[i]);
                end
            end
        end
        repeat (2) @(negedge clk);
        total++;
        if (Step !== 32'd25) begin
            bad++;
            $display("FAIL clamp_hold got=%0d exp=25", Step);
        end
    endtask

    task automatic test_overflow();
        run_and_check_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd20, 16'd0, 2'd0, 32'hA5A5_0000, 0, 1'b0);
        total++;
        if (obs_vals.size() != 2 || obs_vals[0] != 32'hFFFF_FFF0 || obs_vals[1] != 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL overflow_values got_count=%0d exp=FFFFFFF0,FFFFFFFF", obs_vals.size());
        end
    endtask

    task automatic test_updown();
        logic [31:0] exp_list[7];
        exp_list = '{32'd0, 32'd10, 32'd20, 32'd10, 32'd0, 32'd10, 32'd20};
        run_and_check_sweep(32'd0, 32'd20, 32'd10, 16'd0, 2'd2, 32'h0000_0400, 14, 1'b1);
        total++;
        if (obs_vals.size() < 7) begin
            bad++;
            $display("FAIL updown_count got=%0d exp>=7", obs_vals.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                total++;
                if (obs_vals[i] !== exp_list[i]) begin
                    bad++;
                    $display("FAIL updown_value i=%0d got=%0d exp=%0d", i, obs_vals[i], exp_list[i]);
                end
            end
        end
        total++;
        if (obs_done != 0) begin
            bad++;
            $display("FAIL updown_no_done got=%0d exp=0", obs_done);
        end
    endtask

    task automatic test_abort();
        cfg_start = 32'd100;
        cfg_stop  = 32'd130;
        cfg_delta = 32'd10;
        cfg_dwell = 16'd2;
        cfg_mode  = 2'd0;
        cfg_phase = 32'h0000_0777;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (Step !== 32'd110 || busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre got step=%0d busy=%b exp step=110 busy=1", Step, busy);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if ({Step, phase, busy, done, sweep_down} !== {32'd110, 32'h0000_0777, 3'b000}) begin
            bad++;
            $display("FAIL abort_freeze got step=%0d ph=%h busy=%b done=%b exp step=110 ph=777 busy=0 done=0",
                     Step, phase, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || Step !== 32'd110) begin
                bad++;
                $display("FAIL abort_idle i=%0d got done=%b busy=%b step=%0d exp 0 0 110", i, done, busy, Step);
            end
        end
        run_and_check_sweep(32'd100, 32'd130, 32'd10, 16'd2, 2'd0, 32'h0000_0888, 0, 1'b1);
        total++;
        if (obs_busy != 12) begin
            bad++;
            $display("FAIL abort_restart_len got=%0d exp=12", obs_busy);
        end
    endtask

    task automatic test_async_reset();
        cfg_start = 32'd100;
        cfg_stop  = 32'd130;
        cfg_delta = 32'd10;
        cfg_dwell = 16'd2;
        cfg_mode  = 2'd0;
        cfg_phase = 32'hDEAD_BEEF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({Step, phase, busy, done, sweep_down} !== 67'd0) begin
            bad++;
            $display("FAIL async_reset got step=%h ph=%h busy=%b exp all zero", Step, phase, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({Step, phase, busy, done, sweep_down} !== 67'd0) begin
            bad++;
            $display("FAIL reset_release got step=%h ph=%h busy=%b exp all zero", Step, phase, busy);
        end
        cfg_phase = 32'h0000_0011;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({Step, phase, busy, done, sweep_down} !== 67'd0) begin
                bad++;
                $display("FAIL start_abort_idle i=%0d got step=%h ph=%h busy=%b exp all zero",
                         i, Step, phase, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        run_and_check_sweep(32'd5, 32'd35, 32'd15, 16'd1, 2'd3, 32'h0000_0100, 0, 1'b0);
        run_and_check_sweep(32'd50, 32'd40, 32'd7, 16'd2, 2'd0, 32'h0000_0200, 0, 1'b1);
        total++;
        if (obs_busy != 3) begin
            bad++;
            $display("FAIL start_ge_stop_len got=%0d exp=3", obs_busy);
        end
        run_and_check_sweep(32'd7, 32'd7, 32'd3, 16'd1, 2'd1, 32'h0000_0300, 10, 1'b0);
        total++;
        if (obs_vals.size() != 1 || obs_vals[0] != 32'd7) begin
            bad++;
            $display("FAIL repeat_hold_start got_count=%0d exp single value 7", obs_vals.size());
        end
    endtask

    task automatic test_random();
        logic [31:0] s, e, d, ph, t;
        logic [15:0] dw;
        logic [1:0]  m;
        int          rc;
        for (int it = 0; it < 16; it++) begin
            m  = 2'($urandom_range(0, 3));
            dw = 16'($urandom_range(0, 3));
            ph = $urandom;
            rc = int'($urandom_range(20, 60));
            if (it % 5 == 4) begin
                s = 32'hFFFF_FF00 + $urandom_range(0, 64);
                e = 32'hFFFF_FFC0 + $urandom_range(0, 63);
                d = $urandom_range(16, 200);
            end else begin
                s = $urandom_range(0, 200);
                if ($urandom_range(0, 9) == 0) e = $urandom_range(0, 200);
                else e = s + $urandom_range(0, 250);
                d = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom_range(1, 40);
            end
            if (m == 2'd2 && s > e) begin
                t = s;
                s = e;
                e = t;
            end
            run_and_check_sweep(s, e, d, dw, m, ph, rc, 1'b1);
        end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_start = '0;
        cfg_stop  = '0;
        cfg_delta = '0;
        cfg_dwell = '0;
        cfg_mode  = '0;
        cfg_phase = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_clamp();
        test_overflow();
        test_updown();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
